// File: rtl/aes_pkg.sv
// Shared AES definitions for the key-schedule slice: block width, round count,
// key-sequencer state encoding, Rcon constants and the S-box lookup.
// Latency: n/a (constants and pure functions). Backpressure: n/a.
package aes_pkg;

  localparam int         AES_BLOCK_SIZE = 128;
  localparam logic [3:0] AES_ROUNDS_128 = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EMIT_FWD = 2'd1,
    ST_EXPAND   = 2'd2,
    ST_EMIT_REV = 2'd3
  } key_state_e;

  // Rcon high bytes, indexed by the round number of the key being produced.
  // Entry 0 is never used by the schedule.
  localparam logic [10:0][7:0] AES_RCON = {
    8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00
  };

  function automatic logic [7:0] aes_rcon_byte(input logic [3:0] round);
    logic [7:0] r;
    r = 8'h00;
    if (round >= 4'd1 && round <= AES_ROUNDS_128) r = AES_RCON[round];
    return r;
  endfunction

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] aes_gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (x^254, so 0 maps to 0) followed by the
  // affine transform. Keeps the table out of the source; synthesis flattens it.
  function automatic logic [7:0] aes_sbox(input logic [7:0] x);
    logic [7:0] sq, inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = aes_gf_mul(sq, sq);
      inv = aes_gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_key_expand_step.sv
// One AES-128 key-schedule step: next round key from current key and Rcon byte.
// Latency: combinational. Backpressure: none (pure function of inputs).
// Ports: key_i (current key, w0 in [127:96]), rcon_i (Rcon high byte),
//        next_key_o (following round key).
module aes_key_expand_step
  import aes_pkg::*;
(
  input  logic [AES_BLOCK_SIZE-1:0] key_i,
  input  logic [7:0]                rcon_i,
  output logic [AES_BLOCK_SIZE-1:0] next_key_o
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, t;
  logic [31:0] n0, n1, n2, n3;

  assign w0 = key_i[127:96];
  assign w1 = key_i[95:64];
  assign w2 = key_i[63:32];
  assign w3 = key_i[31:0];

  assign rot = {w3[23:0], w3[31:24]};
  assign t   = {aes_sbox(rot[31:24]), aes_sbox(rot[23:16]),
                aes_sbox(rot[15:8]),  aes_sbox(rot[7:0])} ^ {rcon_i, 24'h000000};

  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign next_key_o = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_key_expansion_seq.sv
// Iterative AES-128 key schedule streaming round keys 0..10 (or 10..0) one per clock.
// Latency: forward key 0 valid the cycle after Start; reverse key 10 valid 10 cycles later.
// Backpressure: Round_key_ready low holds key/idx/valid stable; Start accepted only in IDLE.
// Ports: Clk, Rst_n (async active-low); Start/Start_ready/Key handshake;
//        Round_key/Round_idx/Round_key_valid/Round_key_ready output stream.
// Optional macro AES_KEY_REVERSE_EN adds the Decrypt port, the 11-entry key
// buffer and the EXPAND/EMIT_REV states for reverse-order streaming.
module aes_key_expansion_seq
  import aes_pkg::*;
(
  input  logic                      Clk,
  input  logic                      Rst_n,
  input  logic                      Start,
  output logic                      Start_ready,
  input  logic [AES_BLOCK_SIZE-1:0] Key,
`ifdef AES_KEY_REVERSE_EN
  input  logic                      Decrypt,
`endif
  output logic [AES_BLOCK_SIZE-1:0] Round_key,
  output logic [3:0]                Round_idx,
  output logic                      Round_key_valid,
  input  logic                      Round_key_ready
);

  key_state_e                state_q, state_d;
  logic [AES_BLOCK_SIZE-1:0] key_q, key_d;
  logic [3:0]                idx_q, idx_d;
  logic                      valid_q, valid_d;
  logic                      srdy_q;
  logic [AES_BLOCK_SIZE-1:0] step_key;
  logic                      start_acc, xfer;

  assign start_acc = Start & srdy_q;
  assign xfer      = valid_q & Round_key_ready;

  // The step always produces the key for round idx_q+1, in both the forward
  // emit path and the reverse pre-expansion.
  aes_key_expand_step u_step (
    .key_i      (key_q),
    .rcon_i     (aes_rcon_byte(idx_q + 4'd1)),
    .next_key_o (step_key)
  );

`ifdef AES_KEY_REVERSE_EN
  logic [AES_BLOCK_SIZE-1:0] key_buf_q [0:10];
  logic                      buf_we;
  logic [3:0]                buf_waddr;
  logic [AES_BLOCK_SIZE-1:0] buf_wdata;

  // Key buffer has no reset: entries are always written before being read.
  always_ff @(posedge Clk) begin
    if (buf_we) key_buf_q[buf_waddr] <= buf_wdata;
  end
`endif

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    valid_d = valid_q;
`ifdef AES_KEY_REVERSE_EN
    buf_we    = 1'b0;
    buf_waddr = idx_q + 4'd1;
    buf_wdata = step_key;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_acc) begin
          key_d = Key;
          idx_d = 4'd0;
`ifdef AES_KEY_REVERSE_EN
          if (Decrypt) begin
            state_d   = ST_EXPAND;
            buf_we    = 1'b1;
            buf_waddr = 4'd0;
            buf_wdata = Key;
          end else
`endif
          begin
            state_d = ST_EMIT_FWD;
            valid_d = 1'b1;
          end
        end
      end
      ST_EMIT_FWD: begin
        if (xfer) begin
          if (idx_q == AES_ROUNDS_128) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
          end else begin
            key_d = step_key;
            idx_d = idx_q + 4'd1;
          end
        end
      end
`ifdef AES_KEY_REVERSE_EN
      ST_EXPAND: begin
        // key_q tracks the latest expanded key; it is not visible while valid=0.
        key_d  = step_key;
        idx_d  = idx_q + 4'd1;
        buf_we = 1'b1;
        if (idx_q == AES_ROUNDS_128 - 4'd1) begin
          state_d = ST_EMIT_REV;
          valid_d = 1'b1;
        end
      end
      ST_EMIT_REV: begin
        if (xfer) begin
          if (idx_q == 4'd0) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
          end else begin
            idx_d = idx_q - 4'd1;
            key_d = key_buf_q[idx_q - 4'd1];
          end
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      idx_q   <= 4'd0;
      valid_q <= 1'b0;
      srdy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      // Registered so Start_ready first rises one edge after reset release.
      srdy_q  <= (state_d == ST_IDLE);
    end
  end

  assign Start_ready     = srdy_q;
  assign Round_key       = key_q;
  assign Round_idx       = idx_q;
  assign Round_key_valid = valid_q;

endmodule

// File: tb/tb_aes_key_expansion_seq.sv
// Scoreboard bench for aes_key_expansion_seq: FIPS-197 vectors, random keys,
// random backpressure, busy-Start, mid-stream reset and back-to-back streams.
module tb_aes_key_expansion_seq;

  logic         Clk = 1'b0;
  logic         Rst_n = 1'b0;
  logic         Start = 1'b0;
  logic         Start_ready;
  logic [127:0] Key = '0;
  logic         Decrypt = 1'b0;
  logic [127:0] Round_key;
  logic [3:0]   Round_idx;
  logic         Round_key_valid;
  logic         Round_key_ready = 1'b1;

  aes_key_expansion_seq dut (
    .Clk             (Clk),
    .Rst_n           (Rst_n),
    .Start           (Start),
    .Start_ready     (Start_ready),
    .Key             (Key),
`ifdef AES_KEY_REVERSE_EN
    .Decrypt         (Decrypt),
`endif
    .Round_key       (Round_key),
    .Round_idx       (Round_idx),
    .Round_key_valid (Round_key_valid),
    .Round_key_ready (Round_key_ready)
  );

  always #5 Clk = ~Clk;

  localparam logic [2047:0] SBOX_HEX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] key;
  } exp_t;

  exp_t         exp_q[$];
  int           xfer_edges[$];
  int           cyc = 0;
  int           total = 0;
  int           bad = 0;
  bit           rnd_rdy = 1'b0;
  logic [127:0] mk [0:10];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] sb(input logic [7:0] x);
    return SBOX_HEX[2047 - 8 * int'(x) -: 8];
  endfunction

  // Word-array key schedule straight from FIPS-197; Rcon generated by xtime.
  task automatic build_model(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i - 1];
      if (i % 4 == 0) begin
        tmp = {sb(tmp[23:16]), sb(tmp[15:8]), sb(tmp[7:0]), sb(tmp[31:24])} ^ {rc, 24'h0};
        rc  = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i - 4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) mk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge Clk);
      #1;
      Round_key_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: scoreboard pops on every transfer; stall stability; Start_ready low while busy.
  bit           stall_prev = 1'b0;
  logic [127:0] stall_key;
  logic [3:0]   stall_idx;
  always @(negedge Clk) begin
    exp_t e;
    if (!Rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", 128'(Round_key_valid), 128'd1);
        check("stall_key", Round_key, stall_key);
        check("stall_idx", 128'(Round_idx), 128'(stall_idx));
      end
      if (Round_key_valid) check("busy_start_ready", 128'(Start_ready), 128'd0);
      if (Round_key_valid && Round_key_ready) begin
        xfer_edges.push_back(cyc + 1);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_xfer: got idx %0d, expected no transfer", Round_idx);
        end else begin
          e = exp_q.pop_front();
          check("xfer_idx", 128'(Round_idx), 128'(e.idx));
          check("xfer_key", Round_key, e.key);
        end
      end
      stall_prev = Round_key_valid && !Round_key_ready;
      stall_key  = Round_key;
      stall_idx  = Round_idx;
    end
  end

  task automatic do_start(input logic [127:0] k, input bit dec, output int acc);
    int n = 0;
    @(posedge Clk);
    #1;
    while (!Start_ready && n < 300) begin
      @(posedge Clk);
      #1;
      n++;
    end
    if (!Start_ready) begin
      total++;
      bad++;
      $display("FAIL start_timeout: got Start_ready 0, expected 1");
      acc = -1;
      return;
    end
    Start   = 1'b1;
    Key     = k;
    Decrypt = dec;
    build_model(k);
    for (int r = 0; r < 11; r++) begin
      exp_t e;
      e.idx = dec ? 4'(10 - r) : 4'(r);
      e.key = mk[e.idx];
      exp_q.push_back(e);
    end
    @(posedge Clk);
    #1;
    acc     = cyc;
    Start   = 1'b0;
    Decrypt = 1'b0;
    Key     = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || !Start_ready) && n < 500) begin
      @(posedge Clk);
      #1;
      n++;
    end
    check(name, 128'(exp_q.size()), 128'd0);
  endtask

  task automatic wait_idx(input logic [3:0] idx);
    int n = 0;
    while (!(Round_key_valid && Round_idx == idx) && n < 300) begin
      @(posedge Clk);
      #1;
      n++;
    end
    check("wait_idx_reached", 128'(Round_idx), 128'(idx));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc2;
    logic [127:0] k;
    bit dec;

    // Reset state
    repeat (3) @(posedge Clk);
    #1;
    check("rst_start_ready", 128'(Start_ready), 128'd0);
    check("rst_valid", 128'(Round_key_valid), 128'd0);
    check("rst_key", Round_key, 128'd0);
    check("rst_idx", 128'(Round_idx), 128'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    #1;
    check("srdy_before_edge", 128'(Start_ready), 128'd0);
    @(posedge Clk);
    #1;
    check("srdy_after_edge", 128'(Start_ready), 128'd1);

    // FIPS-197 forward, ready held high
    build_model(FIPS_KEY);
    check("model_fips_idx1", mk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("model_fips_idx10", mk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    xfer_edges.delete();
    do_start(FIPS_KEY, 1'b0, acc);
    wait_drain("fwd_drain");
    check("fwd_count", 128'(xfer_edges.size()), 128'd11);
    if (xfer_edges.size() == 11) begin
      check("fwd_first_edge", 128'(xfer_edges[0]), 128'(acc + 1));
      check("fwd_last_edge", 128'(xfer_edges[10]), 128'(acc + 11));
    end

    // Random backpressure
    rnd_rdy = 1'b1;
    do_start(FIPS_KEY, 1'b0, acc);
    wait_drain("bp_drain");
    rnd_rdy = 1'b0;

`ifdef AES_KEY_REVERSE_EN
    // Reverse order
    xfer_edges.delete();
    do_start(FIPS_KEY, 1'b1, acc);
    wait_drain("rev_drain");
    check("rev_count", 128'(xfer_edges.size()), 128'd11);
    if (xfer_edges.size() == 11) begin
      check("rev_first_edge", 128'(xfer_edges[0]), 128'(acc + 11));
      check("rev_last_edge", 128'(xfer_edges[10]), 128'(acc + 21));
    end
`endif

    // Start while busy is ignored
    do_start(FIPS_KEY, 1'b0, acc);
    wait_idx(4'd5);
    check("busy_srdy_at_idx5", 128'(Start_ready), 128'd0);
    Start = 1'b1;
    Key   = '0;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    wait_drain("busy_drain");
    repeat (3) @(posedge Clk);
    #1;
    check("busy_no_extra_stream", 128'(Round_key_valid), 128'd0);

    // Reset mid-stream
    do_start(FIPS_KEY, 1'b0, acc);
    wait_idx(4'd4);
    Rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_valid", 128'(Round_key_valid), 128'd0);
    check("midrst_idx", 128'(Round_idx), 128'd0);
    check("midrst_key", Round_key, 128'd0);
    check("midrst_srdy", 128'(Start_ready), 128'd0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    do_start(128'd0, 1'b0, acc);
    check("model_zero_idx1", mk[1], 128'h62636363626363636263636362636363);
    wait_drain("zero_drain");

    // Back-to-back streams
    xfer_edges.delete();
    do_start({$urandom, $urandom, $urandom, $urandom}, 1'b0, acc);
    do_start({$urandom, $urandom, $urandom, $urandom}, 1'b0, acc2);
    wait_drain("b2b_drain");
    check("b2b_count", 128'(xfer_edges.size()), 128'd22);
    check("b2b_accept_gap", 128'(acc2), 128'(acc + 12));
    if (xfer_edges.size() == 22)
      check("b2b_idle_gap", 128'(xfer_edges[11]), 128'(xfer_edges[10] + 2));

    // Random keys, random backpressure (and random direction when available)
    for (int it = 0; it < 8; it++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
`ifdef AES_KEY_REVERSE_EN
      dec = 1'($urandom_range(0, 1));
`else
      dec = 1'b0;
`endif
      rnd_rdy = 1'($urandom_range(0, 1));
      do_start(k, dec, acc);
      wait_drain("rand_drain");
    end
    rnd_rdy = 1'b0;

    repeat (2) @(posedge Clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
